// File: rtl/rv_host_byte_tx.sv
// Streams a block of 32-bit memory words to the host as bytes (LSB first) over a
// four-phase req/ack handshake; host_ack is asynchronous and synchronized locally.
module rv_host_byte_tx #(
  parameter int ADDR_W      = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              host_ack,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, RELEASE, FIN} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [ADDR_W-1:0]      cur_addr, cur_addr_d, mem_addr_d;
  logic [CNT_W-1:0]       remaining, remaining_d;
  logic [31:0]            word_q, word_d;
  logic [1:0]             byte_idx, byte_idx_d;
  logic [7:0]             tx_data_d;
  logic                   mem_req_d, tx_valid_d, busy_d, done_d;
  logic                   last_byte, byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], host_ack};
  end

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign last_byte = (byte_idx == 2'd3);
  assign byte_done = (state == RELEASE) && !ack_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = (word_count == '0) ? FIN : FETCH;
      FETCH:   if (mem_rvalid) state_d = SEND;
      // Leave SEND only after our own req has been seen high together with ack.
      SEND:    if (tx_valid && ack_s) state_d = RELEASE;
      RELEASE: if (!ack_s) begin
                 if (!last_byte)                    state_d = SEND;
                 else if (remaining == CNT_W'(1))   state_d = FIN;
                 else                               state_d = FETCH;
               end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_addr_d  = cur_addr;
    remaining_d = remaining;
    word_d      = word_q;
    byte_idx_d  = byte_idx;
    tx_data_d   = tx_data;
    if (state == IDLE && start) begin
      cur_addr_d  = start_addr;
      remaining_d = word_count;
    end
    if (state == FETCH && mem_rvalid) begin
      word_d     = mem_rdata;
      byte_idx_d = 2'd0;
    end
    if (byte_done) begin
      if (!last_byte) begin
        byte_idx_d = byte_idx + 2'd1;
      end else begin
        remaining_d = remaining - CNT_W'(1);
        cur_addr_d  = cur_addr + ADDR_W'(1);
      end
    end
    if (state == SEND) begin
      case (byte_idx)
        2'd0:    tx_data_d = word_q[7:0];
        2'd1:    tx_data_d = word_q[15:8];
        2'd2:    tx_data_d = word_q[23:16];
        default: tx_data_d = word_q[31:24];
      endcase
    end
    mem_req_d  = (state_d == FETCH);
    mem_addr_d = mem_req_d ? cur_addr_d : mem_addr;
    // Raise req only once ack_s is low; keep it up until ack is seen.
    tx_valid_d = (state == SEND) && (state_d == SEND) && (tx_valid || !ack_s);
    busy_d     = (state_d != IDLE);
    done_d     = (state == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      word_q    <= '0;
      byte_idx  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur_addr  <= cur_addr_d;
      remaining <= remaining_d;
      word_q    <= word_d;
      byte_idx  <= byte_idx_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
